// File: rtl/fg_burst_gen_if.sv
// Descriptor input and AXI-stream output bundle for fg_burst_gen.
// master is the generator's view; slave is the view of whoever feeds descriptors and sinks the stream.
interface fg_burst_gen_if #(
  parameter int DEST_WIDTH = 8
);
  logic                  input_bd_valid;
  logic                  input_bd_ready;
  logic [DEST_WIDTH-1:0] input_bd_dest;
  logic [31:0]           input_bd_burst_len;
  logic [7:0]            output_axis_tdata;
  logic                  output_axis_tvalid;
  logic                  output_axis_tready;
  logic                  output_axis_tlast;
  logic [DEST_WIDTH-1:0] output_axis_tdest;

  modport master (
    input  input_bd_valid, input_bd_dest, input_bd_burst_len, output_axis_tready,
    output input_bd_ready, output_axis_tdata, output_axis_tvalid, output_axis_tlast,
    output_axis_tdest
  );

  modport slave (
    output input_bd_valid, input_bd_dest, input_bd_burst_len, output_axis_tready,
    input  input_bd_ready, output_axis_tdata, output_axis_tvalid, output_axis_tlast,
    output_axis_tdest
  );
endinterface

// File: rtl/fg_burst_gen.sv
// Burst generator: turns (dest, length) descriptors into byte frames of at most MAX_FRAME_LEN bytes.
// Define FG_BURST_GEN_SEQ_EN to replace the first byte of each frame with an 8-bit frame sequence number.
module fg_burst_gen #(
  parameter int DEST_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1500
) (
  input  logic                 clk,
  input  logic                 rst,
  fg_burst_gen_if.master       bus,
  output logic                 busy,
  output logic [31:0]          frame_count,
  output logic [31:0]          byte_count
);
  localparam int         FRW       = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] BURST     = 1'b1;
  localparam logic [31:0] MAX_LEN32 = 32'(MAX_FRAME_LEN);

  logic [0:0]            state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [31:0]           burstRem_q, burstRem_d;
  logic [FRW-1:0]        frameRem_q, frameRem_d;
  logic [7:0]            offset_q, offset_d;
  logic [31:0]           frameCount_q, frameCount_d;
  logic [31:0]           byteCount_q, byteCount_d;
`ifdef FG_BURST_GEN_SEQ_EN
  logic [7:0]            seq_q, seq_d;
  logic                  firstBeat_q, firstBeat_d;
`endif

  function automatic logic [FRW-1:0] frameLen(input logic [31:0] remaining);
    return (remaining < MAX_LEN32) ? FRW'(remaining) : FRW'(MAX_FRAME_LEN);
  endfunction

  logic beatLast;
  assign beatLast = (frameRem_q == FRW'(1));

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    burstRem_d   = burstRem_q;
    frameRem_d   = frameRem_q;
    offset_d     = offset_q;
    frameCount_d = frameCount_q;
    byteCount_d  = byteCount_q;
`ifdef FG_BURST_GEN_SEQ_EN
    seq_d        = seq_q;
    firstBeat_d  = firstBeat_q;
`endif
    case (state_q)
      IDLE: begin
        // Zero-length descriptors are simply swallowed without leaving IDLE.
        if (bus.input_bd_valid && (bus.input_bd_burst_len != 32'd0)) begin
          state_d    = BURST;
          dest_d     = bus.input_bd_dest;
          burstRem_d = bus.input_bd_burst_len;
          frameRem_d = frameLen(bus.input_bd_burst_len);
          offset_d   = 8'd0;
`ifdef FG_BURST_GEN_SEQ_EN
          firstBeat_d = 1'b1;
`endif
        end
      end
      default: begin
        if (bus.output_axis_tready) begin
          offset_d    = offset_q + 8'd1;
          byteCount_d = byteCount_q + 32'd1;
          burstRem_d  = burstRem_q - 32'd1;
          frameRem_d  = frameRem_q - FRW'(1);
`ifdef FG_BURST_GEN_SEQ_EN
          firstBeat_d = 1'b0;
`endif
          if (beatLast) begin
            frameCount_d = frameCount_q + 32'd1;
            frameRem_d   = frameLen(burstRem_q - 32'd1);
`ifdef FG_BURST_GEN_SEQ_EN
            seq_d       = seq_q + 8'd1;
            firstBeat_d = 1'b1;
`endif
          end
          if (burstRem_q == 32'd1) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      burstRem_q   <= '0;
      frameRem_q   <= '0;
      offset_q     <= '0;
      frameCount_q <= '0;
      byteCount_q  <= '0;
`ifdef FG_BURST_GEN_SEQ_EN
      seq_q        <= '0;
      firstBeat_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      burstRem_q   <= burstRem_d;
      frameRem_q   <= frameRem_d;
      offset_q     <= offset_d;
      frameCount_q <= frameCount_d;
      byteCount_q  <= byteCount_d;
`ifdef FG_BURST_GEN_SEQ_EN
      seq_q        <= seq_d;
      firstBeat_q  <= firstBeat_d;
`endif
    end
  end

  assign bus.input_bd_ready     = (state_q == IDLE);
  assign bus.output_axis_tvalid = (state_q == BURST);
  assign bus.output_axis_tlast  = (state_q == BURST) && beatLast;
  assign bus.output_axis_tdest  = dest_q;
`ifdef FG_BURST_GEN_SEQ_EN
  assign bus.output_axis_tdata  = firstBeat_q ? seq_q : offset_q;
`else
  assign bus.output_axis_tdata  = offset_q;
`endif
  assign busy        = (state_q == BURST);
  assign frame_count = frameCount_q;
  assign byte_count  = byteCount_q;
endmodule

// File: tb/tb_fg_burst_gen.sv
// Self-checking bench for fg_burst_gen: a queue-of-beats reference model plus directed and random bursts.
// Honours FG_BURST_GEN_SEQ_EN by switching to 2-byte frames and sequence-numbered first bytes.
module tb_fg_burst_gen;
`ifdef FG_BURST_GEN_SEQ_EN
  localparam int MAXF = 2;
`else
  localparam int MAXF = 4;
`endif

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] dest;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] frameCount;
  logic [31:0] byteCount;

  fg_burst_gen_if #(.DEST_WIDTH(8)) dutIf ();

  fg_burst_gen #(.DEST_WIDTH(8), .MAX_FRAME_LEN(MAXF)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (dutIf.master),
    .busy        (busy),
    .frame_count (frameCount),
    .byte_count  (byteCount)
  );

  always #5 clk = ~clk;

  int    assertCount = 0;
  int    failCount   = 0;
  int    acceptCount = 0;
  int    cycleNo     = 0;
  int    mFrames     = 0;
  int    mBytes      = 0;
  bit    checkEn     = 1'b0;
  bit    randReady   = 1'b0;
  beat_t mq[$];
  beat_t beatLog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycleNo++;

  // Reference model: a descriptor expands into its full list of beats, the sink drains one per ready cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mFrames = 0;
      mBytes  = 0;
    end else begin
      if (dutIf.output_axis_tvalid && dutIf.output_axis_tready)
        beatLog.push_back('{dutIf.output_axis_tdata, dutIf.output_axis_tlast, dutIf.output_axis_tdest});
      if (mq.size() != 0) begin
        if (dutIf.output_axis_tready) begin
          beat_t b;
          b = mq.pop_front();
          mBytes++;
          if (b.last) mFrames++;
        end
      end else if (dutIf.input_bd_valid) begin
        int len;
        len = int'(dutIf.input_bd_burst_len);
        acceptCount++;
        for (int i = 0; i < len; i++) begin
          beat_t b;
          b.dest = dutIf.input_bd_dest;
          b.last = ((i % MAXF) == MAXF - 1) || (i == len - 1);
          b.data = 8'(i);
`ifdef FG_BURST_GEN_SEQ_EN
          if ((i % MAXF) == 0) b.data = 8'(mFrames + i / MAXF);
`endif
          mq.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && checkEn) begin
      bit idle;
      idle = (mq.size() == 0);
      check("bd_ready", dutIf.input_bd_ready, idle);
      check("tvalid", dutIf.output_axis_tvalid, !idle);
      check("busy", busy, !idle);
      check("frame_count", frameCount, mFrames);
      check("byte_count", byteCount, mBytes);
      if (!idle) begin
        check("tdata", dutIf.output_axis_tdata, mq[0].data);
        check("tlast", dutIf.output_axis_tlast, mq[0].last);
        check("tdest", dutIf.output_axis_tdest, mq[0].dest);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (randReady) dutIf.output_axis_tready = ($urandom % 4) != 0;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] dest, input logic [31:0] len);
    dutIf.input_bd_valid     = valid;
    dutIf.input_bd_dest      = dest;
    dutIf.input_bd_burst_len = len;
  endtask

  task automatic sendDesc(input logic [7:0] dest, input logic [31:0] len);
    int start;
    int n;
    start = acceptCount;
    n = 0;
    applyStimulus(1'b1, dest, len);
    while (acceptCount == start && n < 5000) begin
      tick();
      n++;
    end
    check("accept_timeout", (n < 5000), 1);
    applyStimulus(1'b0, 8'h00, 32'd0);
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (mq.size() != 0 && cycles < 5000) begin
      tick();
      cycles++;
    end
    check("idle_timeout", (cycles < 5000), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    beatLog.delete();
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [7:0] data, input logic last);
    if (idx < beatLog.size()) begin
      check({name, "_data"}, beatLog[idx].data, data);
      check({name, "_last"}, beatLog[idx].last, last);
    end else begin
      check({name, "_missing"}, 0, 1);
    end
  endtask

  initial begin
    int cyc;
    int c0;
    applyStimulus(1'b0, 8'h00, 32'd0);
    dutIf.output_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bd_ready", dutIf.input_bd_ready, 1);
    check("rst_tvalid", dutIf.output_axis_tvalid, 0);
    check("rst_tlast", dutIf.output_axis_tlast, 0);
    check("rst_tdata", dutIf.output_axis_tdata, 0);
    check("rst_tdest", dutIf.output_axis_tdest, 0);
    check("rst_busy", busy, 0);
    check("rst_frames", frameCount, 0);
    check("rst_bytes", byteCount, 0);
    rst = 1'b0;
    checkEn = 1'b1;

    // Single burst: first beat one cycle after accept.
    sendDesc(8'h3A, 32'd5);
    check("t1_first_valid", dutIf.output_axis_tvalid, 1);
    check("t1_first_data", dutIf.output_axis_tdata, 8'h00);
    check("t1_first_dest", dutIf.output_axis_tdest, 8'h3A);
    waitIdle(cyc);
    check("t1_bytes", byteCount, 5);
`ifdef FG_BURST_GEN_SEQ_EN
    check("t1_frames", frameCount, 3);
`else
    check("t1_frames", frameCount, 2);
`endif

    // Split burst, contiguous beats.
    doReset();
`ifdef FG_BURST_GEN_SEQ_EN
    sendDesc(8'h11, 32'd6);
    waitIdle(cyc);
    check("t2_cycles", cyc, 6);
    check("t2_frames", frameCount, 3);
    checkOutput("t2_b0", 0, 8'h00, 1'b0);
    checkOutput("t2_b1", 1, 8'h01, 1'b1);
    checkOutput("t2_b2", 2, 8'h01, 1'b0);
    checkOutput("t2_b3", 3, 8'h03, 1'b1);
    checkOutput("t2_b4", 4, 8'h02, 1'b0);
    checkOutput("t2_b5", 5, 8'h05, 1'b1);
`else
    sendDesc(8'h11, 32'd10);
    waitIdle(cyc);
    check("t2_cycles", cyc, 10);
    check("t2_frames", frameCount, 3);
    for (int i = 0; i < 10; i++)
      checkOutput("t2_beat", i, 8'(i), (i == 3) || (i == 7) || (i == 9));
`endif

    // Backpressure: tready 1,0,0,1,1 across the burst.
    doReset();
    begin
      bit pat [5];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      dutIf.output_axis_tready = 1'b1;
      sendDesc(8'h22, 32'd3);
      for (int i = 1; i < 5; i++) begin
        tick();
        dutIf.output_axis_tready = pat[i];
      end
      waitIdle(cyc);
    end
    check("t3_count", beatLog.size(), 3);
    checkOutput("t3_b0", 0, 8'h00, 1'b0);
`ifdef FG_BURST_GEN_SEQ_EN
    checkOutput("t3_b1", 1, 8'h01, 1'b1);
    checkOutput("t3_b2", 2, 8'h01, 1'b1);
`else
    checkOutput("t3_b1", 1, 8'h01, 1'b0);
    checkOutput("t3_b2", 2, 8'h02, 1'b1);
`endif

    // Zero-length descriptors back to back, then a 1-byte burst right after tlast.
    doReset();
    c0 = cycleNo;
    sendDesc(8'h01, 32'd0);
    sendDesc(8'h02, 32'd0);
    sendDesc(8'h03, 32'd2);
    check("t4_accept_cycles", cycleNo - c0, 3);
    sendDesc(8'h04, 32'd1);
    waitIdle(cyc);
    check("t4_count", beatLog.size(), 3);
    checkOutput("t4_b1", 1, 8'h01, 1'b1);
    check("t4_b2_last", beatLog.size() > 2 ? beatLog[2].last : 1'b0, 1);

    // Reset in the middle of a long burst.
    doReset();
    sendDesc(8'h55, 32'd300);
    cyc = 0;
    while (beatLog.size() < 100 && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("t5_reach100", (cyc < 1000), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_tvalid", dutIf.output_axis_tvalid, 0);
    check("t5_tlast", dutIf.output_axis_tlast, 0);
    check("t5_bd_ready", dutIf.input_bd_ready, 1);
    check("t5_frames", frameCount, 0);
    check("t5_bytes", byteCount, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    beatLog.delete();
    sendDesc(8'h66, 32'd2);
    waitIdle(cyc);
    checkOutput("t5_b0", 0, 8'h00, 1'b0);
    checkOutput("t5_b1", 1, 8'h01, 1'b1);

    // Random descriptors with random sink backpressure.
    randReady = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [31:0] len;
      len = (($urandom % 6) == 0) ? 32'd0 : 32'($urandom_range(1, 13));
      sendDesc(8'($urandom), len);
      repeat ($urandom_range(0, 2)) tick();
    end
    waitIdle(cyc);
    randReady = 1'b0;
    dutIf.output_axis_tready = 1'b1;
    repeat (3) tick();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/fg_burst_gen.md
# fg_burst_gen

Burst generator for the flow generator: consumes burst descriptors (destination, burst length in bytes) from the burst descriptor FIFO and emits each burst as one or more 8-bit AXI-stream frames tagged with that destination. Each burst is split into frames of at most MAX_FRAME_LEN bytes. Sits directly downstream of the descriptor FIFO and drives the flow generator's stream output or mux.

## Interface
- DEST_WIDTH, 8, width of descriptor destination and tdest
- MAX_FRAME_LEN, 1500, maximum frame length in bytes; legal range 1 to 65535
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- input_bd_valid  in  1  descriptor valid
- input_bd_ready  out  1  descriptor accepted when valid & ready
- input_bd_dest  in  DEST_WIDTH  destination for the whole burst
- input_bd_burst_len  in  32  burst length in bytes; 0 allowed
- output_axis_tdata  out  8  payload byte
- output_axis_tvalid  out  1  beat valid
- output_axis_tready  in  1  sink ready
- output_axis_tlast  out  1  last byte of frame
- output_axis_tdest  out  DEST_WIDTH  destination of current frame
- busy  out  1  burst in progress (not IDLE)
- frame_count  out  32  frames completed since reset, wraps
- byte_count  out  32  bytes transferred since reset, wraps

## Operation
- States: IDLE, BURST.
- IDLE: input_bd_ready = 1, registered (state == IDLE). On accept:
  - burst_len = 0: descriptor consumed, no output, stay IDLE.
  - burst_len > 0: latch dest; load burst_rem = burst_len and frame_rem = min(burst_len, MAX_FRAME_LEN); reset offset to 0; go to BURST.
- BURST: input_bd_ready = 0. tvalid = 1. tdata = offset[7:0], where offset is the byte index within the burst and wraps at 256. tlast = (frame_rem == 1).
- On each beat handshake (tvalid & tready):
  - offset and byte_count increment; burst_rem and frame_rem decrement.
  - If tlast: frame_count increments and frame_rem reloads to min(burst_rem-1, MAX_FRAME_LEN).
  - If burst_rem == 1: go to IDLE.
- Arithmetic: burst_rem is 32-bit; frame_rem is clog2(MAX_FRAME_LEN+1) bits; the min comparison is 32-bit. A burst of N bytes gives ceil(N/MAX_FRAME_LEN) frames. Every frame is MAX_FRAME_LEN bytes except the last, which carries the remainder.
- Beats are contiguous across frame boundaries. No bubble inside a burst while tready = 1.
- tdata, tlast and tdest hold stable while tvalid & ~tready.

## Timing
- Reset values: input_bd_ready 1, tvalid 0, tlast 0, tdata 0, tdest 0, busy 0, frame_count 0, byte_count 0.
- Reset mid-burst: all outputs return to reset values immediately. The in-flight descriptor is discarded and no tlast is emitted.
- Descriptor accepted at cycle N → first beat valid at N+1.
- Last beat handshake at cycle M → IDLE at M+1 with input_bd_ready = 1. Next descriptor accepted at M+1 gives its first beat at M+2, a one-cycle gap between bursts.
- Zero-length descriptors are accepted at one per cycle.
- All outputs are registered; there is no combinational path from tready to tvalid or to input_bd_ready.
- Counters update in the cycle after the handshake that causes them.

## Configuration
- FG_BURST_GEN_SEQ_EN
  - Defined: the first byte of every frame carries seq[7:0] instead of offset[7:0]. seq is an 8-bit frame sequence counter that resets to 0, increments per completed frame and wraps 255→0. Offset still advances on that beat.
  - Undefined: no seq register; every byte is offset[7:0].

## Test plan
- Single burst: dest=0x3A, len=5, tready=1 → beats 00 01 02 03 04, tlast on 04, tdest=0x3A. First beat 1 cycle after accept. frame_count=1, byte_count=5.
- Split: MAX_FRAME_LEN=4, len=10 → frames of 4, 4 and 2 bytes, data 00..09 contiguous, tlast on 03, 07 and 09, no gaps. frame_count=3.
- Backpressure: len=3, tready toggling 1,0,0,1,1 → each byte is presented stable until accepted. Sequence 00 01 02 is intact and input_bd_ready stays 0 until after the last handshake.
- Zero length and back-to-back: descriptors len=0, then 0, then 2 on consecutive cycles → all three accepted in 3 cycles and only 2 beats are emitted. A following len=1 descriptor is accepted 1 cycle after tlast.
- Reset mid-burst: len=300, assert rst after 100 beats → tvalid=0 immediately, counters 0 and input_bd_ready=1 after release. A new len=2 burst starts at tdata 00.
- With FG_BURST_GEN_SEQ_EN, MAX_FRAME_LEN=2, len=6 → frames (00,01) (01,03) (02,05).
